// File: rtl/bus_sources.sv
// Address-bus source selects shared by the control unit and the address unit.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package bus_sources;

    typedef enum logic [1:0] {
        AddressLowSrcPcLow      = 2'd0,
        AddressLowSrcAddrLowReg = 2'd1
    } address_low_bus_source_t;

    typedef enum logic [1:0] {
        AddressHighSrcPcHigh      = 2'd0,
        AddressHighSrcAddrHighReg = 2'd1
    } address_high_bus_source_t;

endpackage

// File: rtl/control_signals.sv
// Constants shared between the control unit and the datapath stages.
// Latency: n/a (constants only).
// Backpressure: n/a.
package control_signals;

    // Location of the 6502 reset vector low byte; the high byte follows it.
    localparam logic [15:0] RESET_VECTOR_ADDR = 16'hFFFC;

endpackage

// File: rtl/address_unit_if.sv
// Bundle between the control unit (master) and the address unit (slave).
// Carries data_in, the PC/latch strobes, the bus source selects, and returns
// the external address, the current PC and cpu_ready. No handshake: strobes act at the next edge.
interface address_unit_if;
    import bus_sources::*;

    logic [7:0]               data_in;
    logic                     inc_pc;
    logic                     load_pc;
    logic                     load_addr_low;
    logic                     load_addr_high;
    address_low_bus_source_t  address_low_src;
    address_high_bus_source_t address_high_src;
    logic [15:0]              address;
    logic [15:0]              pc;
    logic                     cpu_ready;

    modport master (
        output data_in, inc_pc, load_pc, load_addr_low, load_addr_high,
               address_low_src, address_high_src,
        input  address, pc, cpu_ready
    );

    modport slave (
        input  data_in, inc_pc, load_pc, load_addr_low, load_addr_high,
               address_low_src, address_high_src,
        output address, pc, cpu_ready
    );

endinterface

// File: rtl/program_counter.sv
// 16-bit program counter: sync reset, load has priority over increment, wraps FFFF->0000.
// Latency: value updates at the clock edge following load/inc.
// Backpressure: none; ports are clk, reset, load, inc, load_value in and value out.
module program_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        inc,
    input  logic [15:0] load_value,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= 16'h0000;
        end else if (load) begin
            value <= load_value;
        end else if (inc) begin
            value <= value + 16'd1;
        end
    end

endmodule

// File: rtl/address_unit.sv
// Owns PC and the ADL/ADH latches, runs the reset-vector fetch, and drives the address bus.
// Latency: address mux is combinational; PC/latch updates land at the next edge.
// Backpressure: none; cpu_ready stays low until the vector fetch finishes. Ports: clk, reset, bus (slave).
module address_unit
    import bus_sources::*;
    import control_signals::*;
#(
    parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_ADDR,
    parameter int          MEM_LATENCY  = 0
) (
    input  logic         clk,
    input  logic         reset,
    address_unit_if.slave bus
);

    if ((MEM_LATENCY != 0) && (MEM_LATENCY != 1)) begin : g_bad_mem_latency
        $error("address_unit: MEM_LATENCY must be 0 or 1");
    end

    // With one cycle of read latency each vector byte needs a wait state
    // where the address is held and the returned byte is captured.
    localparam bit HAS_WAIT = (MEM_LATENCY == 1);

    typedef enum logic [2:0] {
        VecLow,
        VecLowWait,
        VecHigh,
        VecHighWait,
        Run
    } vec_state_t;

    vec_state_t  state;
    vec_state_t  state_nxt;

    logic [15:0] pc_q;
    logic        pc_load;
    logic        pc_inc;
    logic [15:0] pc_load_value;
    logic [15:0] vec_addr;

    logic [7:0]  adl;
    logic [7:0]  adh;
    logic        cpu_ready_q;

    logic [7:0]  addr_lo_mux;
    logic [7:0]  addr_hi_mux;

    program_counter u_pc (
        .clk        (clk),
        .reset      (reset),
        .load       (pc_load),
        .inc        (pc_inc),
        .load_value (pc_load_value),
        .value      (pc_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= VecLow;
        end else begin
            state <= state_nxt;
        end
    end

    // Vector bytes are written into PC one half at a time by reloading the
    // whole register with the other half preserved.
    always_comb begin
        state_nxt     = state;
        pc_load       = 1'b0;
        pc_inc        = 1'b0;
        pc_load_value = {adh, adl};
        vec_addr      = RESET_VECTOR;
        case (state)
            VecLow: begin
                if (HAS_WAIT) begin
                    state_nxt = VecLowWait;
                end else begin
                    pc_load       = 1'b1;
                    pc_load_value = {pc_q[15:8], bus.data_in};
                    state_nxt     = VecHigh;
                end
            end
            VecLowWait: begin
                pc_load       = 1'b1;
                pc_load_value = {pc_q[15:8], bus.data_in};
                state_nxt     = VecHigh;
            end
            VecHigh: begin
                vec_addr = RESET_VECTOR + 16'd1;
                if (HAS_WAIT) begin
                    state_nxt = VecHighWait;
                end else begin
                    pc_load       = 1'b1;
                    pc_load_value = {bus.data_in, pc_q[7:0]};
                    state_nxt     = Run;
                end
            end
            VecHighWait: begin
                vec_addr      = RESET_VECTOR + 16'd1;
                pc_load       = 1'b1;
                pc_load_value = {bus.data_in, pc_q[7:0]};
                state_nxt     = Run;
            end
            Run: begin
                // load_pc wins over inc_pc inside program_counter.
                pc_load = bus.load_pc;
                pc_inc  = bus.inc_pc;
            end
            default: begin
                state_nxt = VecLow;
            end
        endcase
    end

    // Latches only move in Run; PC reads their pre-edge values on load_pc.
    always_ff @(posedge clk) begin
        if (reset) begin
            adl <= 8'h00;
            adh <= 8'h00;
        end else if (state == Run) begin
            if (bus.load_addr_low) begin
                adl <= bus.data_in;
            end
            if (bus.load_addr_high) begin
                adh <= bus.data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_ready_q <= 1'b0;
        end else begin
            cpu_ready_q <= (state_nxt == Run);
        end
    end

    always_comb begin
        addr_lo_mux = 8'h00;
        addr_hi_mux = 8'h00;
        case (bus.address_low_src)
            AddressLowSrcPcLow:      addr_lo_mux = pc_q[7:0];
            AddressLowSrcAddrLowReg: addr_lo_mux = adl;
            default:                 addr_lo_mux = 8'h00;
        endcase
        case (bus.address_high_src)
            AddressHighSrcPcHigh:      addr_hi_mux = pc_q[15:8];
            AddressHighSrcAddrHighReg: addr_hi_mux = adh;
            default:                   addr_hi_mux = 8'h00;
        endcase
    end

    assign bus.address   = (state == Run) ? {addr_hi_mux, addr_lo_mux} : vec_addr;
    assign bus.pc        = pc_q;
    assign bus.cpu_ready = cpu_ready_q;

    a_low_src_legal : assert property (@(posedge clk) disable iff (reset)
        (state == Run) |-> (bus.address_low_src inside {AddressLowSrcPcLow, AddressLowSrcAddrLowReg}));

    a_high_src_legal : assert property (@(posedge clk) disable iff (reset)
        (state == Run) |-> (bus.address_high_src inside {AddressHighSrcPcHigh, AddressHighSrcAddrHighReg}));

endmodule

// File: tb/tb_address_unit.sv
// Bench for address_unit: vector fetch at both memory latencies, a table of Run-mode
// vectors checked through an expected-value queue, and a reset taken mid-fetch.
// No handshake; inputs change #1 after the rising edge, outputs are sampled away from it.
module tb_address_unit;
    import bus_sources::*;

    logic clk;
    logic reset;
    logic use_mem;
    logic [7:0] data_drv;
    logic [7:0] mem1_q;

    int n_cmp;
    int n_err;

    address_unit_if if0 ();
    address_unit_if if1 ();

    address_unit #(.MEM_LATENCY(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    address_unit #(.MEM_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        case (a)
            16'hFFFC: return 8'h34;
            16'hFFFD: return 8'h12;
            default:  return 8'hEE;
        endcase
    endfunction

    // dut0 sees a zero-latency memory, dut1 a memory registered by one cycle.
    assign if0.data_in = use_mem ? mem_rd(if0.address) : data_drv;
    always @(posedge clk) mem1_q <= mem_rd(if1.address);
    assign if1.data_in = mem1_q;

    typedef struct {
        logic        inc;
        logic        ldpc;
        logic        ldlo;
        logic        ldhi;
        logic [7:0]  din;
        logic        lsel;
        logic        hsel;
        logic [15:0] exp_addr;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t tbl[21];
    vec_t exp_q[$];

    function automatic vec_t mkv(input logic inc, input logic ldpc, input logic ldlo,
                                 input logic ldhi, input logic [7:0] din, input logic lsel,
                                 input logic hsel, input logic [15:0] ea, input logic [15:0] ep);
        vec_t v;
        v.inc = inc; v.ldpc = ldpc; v.ldlo = ldlo; v.ldhi = ldhi; v.din = din;
        v.lsel = lsel; v.hsel = hsel; v.exp_addr = ea; v.exp_pc = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drive0(input logic inc, input logic ldpc, input logic ldlo,
                          input logic ldhi, input logic lsel, input logic hsel);
        if0.inc_pc           = inc;
        if0.load_pc          = ldpc;
        if0.load_addr_low    = ldlo;
        if0.load_addr_high   = ldhi;
        if0.address_low_src  = lsel ? AddressLowSrcAddrLowReg : AddressLowSrcPcLow;
        if0.address_high_src = hsel ? AddressHighSrcAddrHighReg : AddressHighSrcPcHigh;
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic run_vec(input int idx, input vec_t v);
        vec_t e;
        drive0(v.inc, v.ldpc, v.ldlo, v.ldhi, v.lsel, v.hsel);
        data_drv = v.din;
        exp_q.push_back(v);
        @(negedge clk);
        check($sformatf("vec%0d_address", idx), if0.address, v.exp_addr);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        check($sformatf("vec%0d_pc", idx), if0.pc, e.exp_pc);
        check($sformatf("vec%0d_ready", idx), {15'h0, if0.cpu_ready}, 16'h0001);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Starting point for the table: pc=1234, ADL=ADH=00.
        tbl[0]  = mkv(0, 0, 0, 0, 8'h00, 0, 0, 16'h1234, 16'h1234);
        tbl[1]  = mkv(1, 0, 0, 0, 8'h00, 0, 0, 16'h1234, 16'h1235);
        tbl[2]  = mkv(0, 0, 0, 0, 8'h00, 1, 1, 16'h0000, 16'h1235);
        tbl[3]  = mkv(1, 0, 1, 0, 8'hCD, 0, 0, 16'h1235, 16'h1236);
        tbl[4]  = mkv(1, 0, 0, 1, 8'hAB, 0, 0, 16'h1236, 16'h1237);
        tbl[5]  = mkv(0, 1, 0, 0, 8'h00, 1, 1, 16'hABCD, 16'hABCD);
        tbl[6]  = mkv(0, 0, 0, 0, 8'h00, 1, 1, 16'hABCD, 16'hABCD);
        tbl[7]  = mkv(0, 0, 1, 1, 8'hFF, 0, 0, 16'hABCD, 16'hABCD);
        tbl[8]  = mkv(0, 0, 0, 0, 8'h00, 1, 0, 16'hABFF, 16'hABCD);
        tbl[9]  = mkv(0, 0, 0, 0, 8'h00, 0, 1, 16'hFFCD, 16'hABCD);
        tbl[10] = mkv(0, 1, 0, 0, 8'h00, 0, 0, 16'hABCD, 16'hFFFF);
        tbl[11] = mkv(1, 0, 0, 0, 8'h00, 0, 0, 16'hFFFF, 16'h0000);
        tbl[12] = mkv(1, 0, 0, 0, 8'h00, 0, 0, 16'h0000, 16'h0001);
        tbl[13] = mkv(0, 0, 1, 0, 8'h00, 0, 0, 16'h0001, 16'h0001);
        tbl[14] = mkv(0, 0, 0, 1, 8'h04, 0, 0, 16'h0001, 16'h0001);
        tbl[15] = mkv(0, 1, 0, 0, 8'h00, 0, 0, 16'h0001, 16'h0400);
        tbl[16] = mkv(0, 0, 0, 1, 8'h20, 0, 0, 16'h0400, 16'h0400);
        tbl[17] = mkv(1, 1, 0, 0, 8'h00, 1, 1, 16'h2000, 16'h2000);
        tbl[18] = mkv(1, 0, 0, 0, 8'h00, 0, 0, 16'h2000, 16'h2001);
        tbl[19] = mkv(0, 1, 1, 1, 8'h77, 0, 0, 16'h2001, 16'h2000);
        tbl[20] = mkv(0, 0, 0, 0, 8'h00, 1, 1, 16'h7777, 16'h2000);

        reset    = 1'b1;
        use_mem  = 1'b1;
        data_drv = 8'h00;
        drive0(0, 0, 0, 0, 0, 0);
        if1.inc_pc           = 1'b0;
        if1.load_pc          = 1'b0;
        if1.load_addr_low    = 1'b0;
        if1.load_addr_high   = 1'b0;
        if1.address_low_src  = AddressLowSrcPcLow;
        if1.address_high_src = AddressHighSrcPcHigh;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pc0", if0.pc, 16'h0000);
        check("rst_ready0", {15'h0, if0.cpu_ready}, 16'h0000);
        check("rst_addr0", if0.address, 16'hFFFC);
        check("rst_pc1", if1.pc, 16'h0000);
        check("rst_ready1", {15'h0, if1.cpu_ready}, 16'h0000);
        check("rst_addr1", if1.address, 16'hFFFC);

        // Strobes held high during the fetch must have no effect.
        drive0(1, 1, 1, 1, 1, 1);
        reset = 1'b0;
        @(negedge clk);
        check("f0_addr_lo", if0.address, 16'hFFFC);
        check("f1_addr_lo_a", if1.address, 16'hFFFC);
        @(posedge clk); #1;
        check("f0_pc_lo", if0.pc, 16'h0034);
        check("f0_ready_early", {15'h0, if0.cpu_ready}, 16'h0000);
        @(negedge clk);
        check("f0_addr_hi", if0.address, 16'hFFFD);
        check("f1_addr_lo_b", if1.address, 16'hFFFC);
        @(posedge clk); #1;
        check("f0_pc", if0.pc, 16'h1234);
        check("f0_ready", {15'h0, if0.cpu_ready}, 16'h0001);
        check("f1_pc_lo", if1.pc, 16'h0034);
        check("f1_ready_early_a", {15'h0, if1.cpu_ready}, 16'h0000);
        drive0(0, 0, 0, 0, 0, 0);
        use_mem = 1'b0;
        @(negedge clk);
        check("f1_addr_hi_a", if1.address, 16'hFFFD);
        @(posedge clk); #1;
        check("f1_ready_early_b", {15'h0, if1.cpu_ready}, 16'h0000);
        @(negedge clk);
        check("f1_addr_hi_b", if1.address, 16'hFFFD);
        @(posedge clk); #1;
        check("f1_pc", if1.pc, 16'h1234);
        check("f1_ready", {15'h0, if1.cpu_ready}, 16'h0001);
        check("f0_pc_hold", if0.pc, 16'h1234);

        for (int i = 0; i < 21; i++) begin
            run_vec(i, tbl[i]);
        end
        check("queue_drained", 16'(exp_q.size()), 16'h0000);

        // Reset from Run, then a second reset while in VecHigh.
        use_mem = 1'b1;
        reset   = 1'b1;
        @(posedge clk); #1;
        check("rr_pc", if0.pc, 16'h0000);
        check("rr_ready", {15'h0, if0.cpu_ready}, 16'h0000);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rr_pc_lo", if0.pc, 16'h0034);
        reset = 1'b1;
        @(negedge clk);
        check("rv_addr_vechigh", if0.address, 16'hFFFD);
        @(posedge clk); #1;
        check("rv_pc", if0.pc, 16'h0000);
        check("rv_ready", {15'h0, if0.cpu_ready}, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        check("rv_addr_restart", if0.address, 16'hFFFC);
        @(posedge clk); #1;
        check("rv_pc_lo", if0.pc, 16'h0034);
        check("rv_ready_early", {15'h0, if0.cpu_ready}, 16'h0000);
        @(negedge clk);
        check("rv_addr_hi", if0.address, 16'hFFFD);
        @(posedge clk); #1;
        check("rv_pc", if0.pc, 16'h1234);
        check("rv_ready_final", {15'h0, if0.cpu_ready}, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/address_unit.md
Name: address_unit

Overview:
Datapath stage directly downstream of the control unit. It owns the 16-bit program counter (PC) and the absolute-address latches (ADL/ADH), and it drives the external address bus from the low/high bus-source selects. After every reset it runs the 6502 reset-vector fetch and loads PC from $FFFC/$FFFD. Until that fetch completes it holds cpu_ready low, and the top level keeps the control unit in reset for as long as cpu_ready is low.

Parameters:
RESET_VECTOR  16'hFFFC  address of the vector low byte; the high byte is at RESET_VECTOR+1
MEM_LATENCY   0  memory read latency in cycles; legal values are 0 and 1 only

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
data_in  in  8  data-in latch value from memory
inc_pc  in  1  CtrlIncEnablePc
load_pc  in  1  CtrlLoadPc
load_addr_low  in  1  CtrlLoadAddrLow
load_addr_high  in  1  CtrlLoadAddrHigh
address_low_src  in  bus_sources::address_low_bus_source_t  low address-bus source select
address_high_src  in  bus_sources::address_high_bus_source_t  high address-bus source select
address  out  16  external address bus
pc  out  16  current PC, for debug and the bench
cpu_ready  out  1  high once the reset-vector fetch is done

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: pc=16'h0000, ADL=8'h00, ADH=8'h00, cpu_ready=0, FSM=VecLow.
- FSM states: VecLow, VecLowWait, VecHigh, VecHighWait, Run.
  - VecLowWait and VecHighWait are entered only when MEM_LATENCY=1.
- VecLow:
  - address = RESET_VECTOR.
  - MEM_LATENCY=0: pc[7:0] <= data_in at the clock edge, then go to VecHigh.
  - MEM_LATENCY=1: go to VecLowWait. VecLowWait keeps the same address, captures data_in into pc[7:0], then goes to VecHigh.
- VecHigh and VecHighWait: same as the low-byte pair but at RESET_VECTOR+1, capturing pc[15:8], then go to Run.
- cpu_ready is registered and rises on the cycle Run is entered.
  - Vector fetch is 2 cycles for MEM_LATENCY=0 and 4 cycles for MEM_LATENCY=1.
- In every vector state, inc_pc, load_pc and the load_addr_* inputs are ignored.
- In Run, all updates happen at the clock edge:
  - load_addr_low: ADL <= data_in.
  - load_addr_high: ADH <= data_in.
  - load_pc: pc <= {ADH, ADL}, using the register values from before this edge.
  - inc_pc (with load_pc low): pc <= pc + 1, wrapping 16'hFFFF -> 16'h0000.
- Priority: load_pc beats inc_pc. If both are asserted, pc = {ADH, ADL} with no increment.
- load_pc together with load_addr_low/high: PC takes the old latch values; the latches take data_in.
- Address mux in Run is combinational and has zero latency from the selects:
  - address[7:0] = PC low when the select is AddressLowSrcPcLow, ADL when it is AddressLowSrcAddrLowReg.
  - address[15:8] = PC high when the select is AddressHighSrcPcHigh, ADH when it is AddressHighSrcAddrHighReg.
  - Any other enum value drives 8'h00 on that byte and fires a simulation-only assertion.
- Reset asserted mid-vector or mid-Run: at the next edge all state returns to reset values and the vector fetch restarts from VecLow.
- An illegal MEM_LATENCY value causes an elaboration-time error.

Decomposition:
- bus_sources package: the address low/high source enums already live here; add no new bus enums.
- control_signals package: add a RESET_VECTOR_ADDR constant (16'hFFFC) and use it as the parameter default.
- The vector FSM enum is local to address_unit.
- One sub-module: program_counter, a 16-bit register with sync reset, load (priority) and increment with wrap. It instantiates once; address_unit holds the FSM, the latches and the mux.

Test Plan:
- Reset, then memory returns $FFFC=8'h34 and $FFFD=8'h12 (MEM_LATENCY=0) -> address shows FFFC then FFFD; pc=16'h1234 and cpu_ready=1 two cycles after reset drops.
- MEM_LATENCY=1 with the same memory -> each vector address is held for 2 cycles; cpu_ready rises 4 cycles after reset drops; pc=16'h1234.
- Run with pc=16'hFFFF, pulse inc_pc -> pc=16'h0000.
- JMP sequence:
  - Cycle 1: load_addr_low with data_in=8'hCD and inc_pc.
  - Cycle 2: load_addr_high with data_in=8'hAB and inc_pc.
  - Cycle 3: load_pc.
  - Required: pc=16'hABCD; address=16'hABCD when both selects point at the latches.
- inc_pc and load_pc together with ADH/ADL=8'h20/8'h00 and pc=16'h0400 -> pc=16'h2000 with no increment.
- Reset asserted for 1 cycle while in VecHigh with pc[7:0] already loaded -> pc=16'h0000 and cpu_ready=0; address=FFFC on the cycle after reset drops; the full vector fetch repeats.
